// File: rtl/fp_cvt_if.sv
// Request/result channel of the fp24 <-> int32 converter.
// The slave view belongs to the converter and the master view to whoever issues requests.
`timescale 1ns/1ps
interface fp_cvt_if #(
  parameter int TAG_W = 6
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [1:0]       op_i;
  logic [31:0]      data_i;
  logic [TAG_W-1:0] tag_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [31:0]      result_o;
  logic [TAG_W-1:0] tag_o;
  logic             sat_o;
  logic             inexact_o;

  modport slave (
    input  in_valid_i, op_i, data_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, tag_o, sat_o, inexact_o
  );

  modport master (
    output in_valid_i, op_i, data_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, tag_o, sat_o, inexact_o
  );
endinterface

// File: rtl/fp_cvt.sv
// Pipelined converter between 32-bit integers and the fp24 format (1/8/15, bias 127).
// The request is latched, then decoded, normalised/shifted, and packed into the output register.
`timescale 1ns/1ps
module fp_cvt #(
  parameter int TAG_W = 6
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  fp_cvt_if.slave bus
);

  logic             stall;

  logic             reqValid_q;
  logic [1:0]       reqOp_q;
  logic [31:0]      reqData_q;
  logic [TAG_W-1:0] reqTag_q;

  logic             decValid_q;
  logic [1:0]       decOp_q;
  logic [TAG_W-1:0] decTag_q;
  logic             decSign_q, decSign_d;
  logic [31:0]      decMag_q, decMag_d;
  logic [7:0]       decExp_q, decExp_d;

  logic             shfValid_q;
  logic [1:0]       shfOp_q;
  logic [TAG_W-1:0] shfTag_q;
  logic             shfSign_q;
  logic             shfZero_q, shfZero_d;
  logic [31:0]      shfMag_q, shfMag_d;
  logic signed [9:0] shfExp_q, shfExp_d;
  logic             shfInexact_q, shfInexact_d;

  logic             outValid_q;
  logic [TAG_W-1:0] outTag_q;
  logic [31:0]      outResult_q, outResult_d;
  logic             outSat_q, outSat_d;
  logic             outInexact_q, outInexact_d;

  logic [5:0]        lzCount;
  logic              lzFound;
  logic signed [9:0] unbiased;
  logic [3:0]        rShift;
  logic [4:0]        lShift;
  logic [15:0]       fpMant;

  // Every stage freezes together while the final result waits for the consumer.
  assign stall          = outValid_q & ~bus.out_ready_i;
  assign bus.in_ready_o = ~stall;

  assign bus.out_valid_o = outValid_q;
  assign bus.result_o    = outResult_q;
  assign bus.tag_o       = outTag_q;
  assign bus.sat_o       = outSat_q;
  assign bus.inexact_o   = outInexact_q;

  always_comb begin
    decSign_d = 1'b0;
    decMag_d  = '0;
    decExp_d  = '0;
    if (!reqOp_q[1]) begin
      decSign_d = (reqOp_q == 2'b00) & reqData_q[31];
      decMag_d  = decSign_d ? (~reqData_q + 32'd1) : reqData_q;
    end else begin
      decSign_d = reqData_q[23];
      decExp_d  = reqData_q[22:15];
      decMag_d  = {16'h0000, 1'b1, reqData_q[14:0]};
    end
  end

  always_comb begin
    shfZero_d    = 1'b0;
    shfMag_d     = '0;
    shfExp_d     = '0;
    shfInexact_d = 1'b0;
    lzCount      = '0;
    lzFound      = 1'b0;
    unbiased     = '0;
    rShift       = '0;
    lShift       = '0;
    fpMant       = decMag_q[15:0];
    if (!decOp_q[1]) begin
      for (int i = 31; i >= 0; i--) begin
        if (!lzFound && decMag_q[i]) begin
          lzCount = 6'(31 - i);
          lzFound = 1'b1;
        end
      end
      shfZero_d    = ~lzFound;
      shfMag_d     = decMag_q << lzCount;
      shfExp_d     = 10'sd158 - $signed({4'b0000, lzCount});
      shfInexact_d = |shfMag_d[15:0];
    end else begin
      unbiased  = $signed({2'b00, decExp_q}) - 10'sd127;
      shfZero_d = (decExp_q == 8'd0);
      shfExp_d  = unbiased;
      // Above 2^31 the magnitude no longer matters: the pack stage clamps.
      if (unbiased < 0) begin
        shfInexact_d = 1'b1;
      end else if (unbiased <= 15) begin
        rShift       = 4'(15 - unbiased);
        shfMag_d     = {16'h0000, fpMant >> rShift};
        shfInexact_d = |(fpMant & ~(16'hFFFF << rShift));
      end else if (unbiased <= 31) begin
        lShift   = 5'(unbiased - 15);
        shfMag_d = {16'h0000, fpMant} << lShift;
      end
    end
  end

  always_comb begin
    outResult_d  = '0;
    outSat_d     = 1'b0;
    outInexact_d = 1'b0;
    if (!shfZero_q) begin
      if (!shfOp_q[1]) begin
        outResult_d  = {8'h00, shfSign_q, shfExp_q[7:0], shfMag_q[30:16]};
        outInexact_d = shfInexact_q;
      end else if (shfExp_q < 0) begin
        outInexact_d = 1'b1;
      end else if (!shfOp_q[0]) begin
        if (shfExp_q >= 10'sd31) begin
          outResult_d = shfSign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
          outSat_d    = ~(shfSign_q && (shfExp_q == 10'sd31) && (shfMag_q == 32'h8000_0000));
        end else begin
          outResult_d  = shfSign_q ? (~shfMag_q + 32'd1) : shfMag_q;
          outInexact_d = shfInexact_q;
        end
      end else begin
        if (shfSign_q) begin
          outSat_d = 1'b1;
        end else if (shfExp_q >= 10'sd32) begin
          outResult_d = 32'hFFFF_FFFF;
          outSat_d    = 1'b1;
        end else begin
          outResult_d  = shfMag_q;
          outInexact_d = shfInexact_q;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reqValid_q   <= 1'b0;
      reqOp_q      <= '0;
      reqData_q    <= '0;
      reqTag_q     <= '0;
      decValid_q   <= 1'b0;
      decOp_q      <= '0;
      decTag_q     <= '0;
      decSign_q    <= 1'b0;
      decMag_q     <= '0;
      decExp_q     <= '0;
      shfValid_q   <= 1'b0;
      shfOp_q      <= '0;
      shfTag_q     <= '0;
      shfSign_q    <= 1'b0;
      shfZero_q    <= 1'b0;
      shfMag_q     <= '0;
      shfExp_q     <= '0;
      shfInexact_q <= 1'b0;
      outValid_q   <= 1'b0;
      outTag_q     <= '0;
      outResult_q  <= '0;
      outSat_q     <= 1'b0;
      outInexact_q <= 1'b0;
    end else if (!stall) begin
      reqValid_q   <= bus.in_valid_i;
      reqOp_q      <= bus.op_i;
      reqData_q    <= bus.data_i;
      reqTag_q     <= bus.tag_i;
      decValid_q   <= reqValid_q;
      decOp_q      <= reqOp_q;
      decTag_q     <= reqTag_q;
      decSign_q    <= decSign_d;
      decMag_q     <= decMag_d;
      decExp_q     <= decExp_d;
      shfValid_q   <= decValid_q;
      shfOp_q      <= decOp_q;
      shfTag_q     <= decTag_q;
      shfSign_q    <= decSign_q;
      shfZero_q    <= shfZero_d;
      shfMag_q     <= shfMag_d;
      shfExp_q     <= shfExp_d;
      shfInexact_q <= shfInexact_d;
      outValid_q   <= shfValid_q;
      outTag_q     <= shfTag_q;
      outResult_q  <= outResult_d;
      outSat_q     <= outSat_d;
      outInexact_q <= outInexact_d;
    end
  end

endmodule

// File: tb/tb_fp_cvt.sv
// Self-checking bench for fp_cvt: directed vectors, randomised traffic against an
// arithmetic reference model, streaming with backpressure, and reset mid-flight.
`timescale 1ns/1ps
module tb_fp_cvt;
  localparam int TAG_W = 6;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  fp_cvt_if #(.TAG_W(TAG_W)) cvtBus ();

  fp_cvt #(.TAG_W(TAG_W)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (cvtBus)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: works on true numeric values and clamps into the target range.
  function automatic void refConvert(input logic [1:0] op, input logic [31:0] d,
                                     output logic [31:0] res, output logic sat, output logic inx);
    longint m, frac, mag, t, lo, hi, mant;
    int p, e;
    res = '0; sat = 1'b0; inx = 1'b0;
    if (op[1] == 1'b0) begin
      if (op == 2'b00 && d[31]) m = -longint'($signed(d));
      else m = longint'(d);
      if (m != 0) begin
        p = 0;
        for (int i = 0; i < 32; i++) if (m >= (longint'(1) << i)) p = i;
        frac = (m - (longint'(1) << p)) << 15;
        res  = {8'h00, (op == 2'b00) & d[31], 8'(127 + p), 15'(frac >> p)};
        inx  = (frac % (longint'(1) << p)) != 0;
      end
    end else if (d[22:15] != 8'd0) begin
      e    = int'(d[22:15]) - 127;
      mant = 32768 + longint'(d[14:0]);
      if (e < 0) begin
        mag = 0; inx = 1'b1;
      end else if (e <= 15) begin
        mag = mant >> (15 - e);
        inx = (mant % (longint'(1) << (15 - e))) != 0;
      end else if (e <= 40) mag = mant << (e - 15);
      else mag = longint'(1) << 50;
      t  = d[23] ? -mag : mag;
      lo = op[0] ? 0 : -(longint'(1) << 31);
      hi = op[0] ? (longint'(1) << 32) - 1 : (longint'(1) << 31) - 1;
      if (t > hi) begin
        res = 32'(hi); sat = 1'b1; inx = 1'b0;
      end else if (t < lo) begin
        res = 32'(lo); sat = 1'b1; inx = 1'b0;
      end else res = 32'(t);
    end
  endfunction

  function automatic logic [31:0] randOperand(input logic [1:0] op);
    logic [31:0] d;
    logic [7:0]  ex;
    if (!op[1]) begin
      case ($urandom_range(0, 4))
        0: d = 32'h8000_0000;
        1: d = 32'h0;
        2: d = $urandom;
        default: d = $urandom >> $urandom_range(0, 31);
      endcase
      if (op == 2'b00 && $urandom_range(0, 1) == 1) d = -d;
    end else begin
      case ($urandom_range(0, 3))
        0: ex = 8'($urandom);
        1: ex = 8'd0;
        2: ex = 8'($urandom_range(110, 165));
        default: ex = 8'($urandom_range(155, 160));
      endcase
      d = {8'($urandom), $urandom_range(0, 1) == 1, ex, 15'($urandom)};
      if ($urandom_range(0, 3) == 0) d[14:0] = '0;
    end
    return d;
  endfunction

  // Issues one request into an idle pipeline and waits (bounded) for its result.
  task automatic runOne(input logic [1:0] op, input logic [31:0] data, input logic [5:0] tag,
                        output logic [31:0] res, output logic [5:0] tg, output logic s,
                        output logic ix, output int latency);
    @(posedge clk_i); #1;
    cvtBus.out_ready_i = 1'b1;
    cvtBus.in_valid_i  = 1'b1;
    cvtBus.op_i        = op;
    cvtBus.data_i      = data;
    cvtBus.tag_i       = tag;
    @(posedge clk_i); #1;
    cvtBus.in_valid_i = 1'b0;
    latency = 0; res = '0; tg = '0; s = 1'b0; ix = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_i);
      if (cvtBus.out_valid_o) begin
        latency = k;
        res = cvtBus.result_o; tg = cvtBus.tag_o;
        s = cvtBus.sat_o; ix = cvtBus.inexact_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (cvtBus.out_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", cvtBus.out_valid_o); end
    checks++; if (cvtBus.result_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_result: got %h expected 00000000", cvtBus.result_o); end
    checks++; if (cvtBus.tag_o !== 6'h0) begin failures++; $display("[TB] FAIL reset_tag: got %h expected 00", cvtBus.tag_o); end
    checks++; if ({cvtBus.sat_o, cvtBus.inexact_o} !== 2'b00) begin failures++; $display("[TB] FAIL reset_flags: got %b expected 00", {cvtBus.sat_o, cvtBus.inexact_o}); end
    @(negedge clk_i); rst_ni = 1'b1;
    @(negedge clk_i);
    checks++; if (cvtBus.in_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b expected 1", cvtBus.in_ready_o); end
    checks++; if (cvtBus.out_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL idle_out_valid: got %b expected 0", cvtBus.out_valid_o); end
  endtask

  task automatic test_int_to_fp();
    logic [1:0]  opTab  [4] = '{2'b00, 2'b00, 2'b01, 2'b00};
    logic [31:0] inTab  [4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0123_4567, 32'h0000_0000};
    logic [31:0] resTab [4] = '{32'h003F_8000, 32'h00BF_8000, 32'h004B_91A2, 32'h0000_0000};
    logic        inxTab [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] res; logic [5:0] tg; logic s, ix; int lat;
    for (int i = 0; i < 4; i++) begin
      runOne(opTab[i], inTab[i], 6'(i + 1), res, tg, s, ix, lat);
      checks++; if (lat != 4) begin failures++; $display("[TB] FAIL i2f_latency[%0d]: got %0d expected 4", i, lat); end
      checks++; if (res !== resTab[i]) begin failures++; $display("[TB] FAIL i2f_result[%0d]: got %h expected %h", i, res, resTab[i]); end
      checks++; if ({s, ix} !== {1'b0, inxTab[i]}) begin failures++; $display("[TB] FAIL i2f_flags[%0d]: got %b expected %b", i, {s, ix}, {1'b0, inxTab[i]}); end
      checks++; if (tg !== 6'(i + 1)) begin failures++; $display("[TB] FAIL i2f_tag[%0d]: got %h expected %h", i, tg, 6'(i + 1)); end
    end
  endtask

  task automatic test_fp_to_int();
    logic [31:0] inTab  [3] = '{32'h0040_C000, 32'h003F_C000, 32'h00BF_C000};
    logic [31:0] resTab [3] = '{32'h0000_0006, 32'h0000_0001, 32'hFFFF_FFFF};
    logic        inxTab [3] = '{1'b0, 1'b1, 1'b1};
    logic [31:0] res; logic [5:0] tg; logic s, ix; int lat;
    for (int i = 0; i < 3; i++) begin
      runOne(2'b10, inTab[i], 6'(i + 10), res, tg, s, ix, lat);
      checks++; if (res !== resTab[i]) begin failures++; $display("[TB] FAIL f2i_result[%0d]: got %h expected %h (latency %0d)", i, res, resTab[i], lat); end
      checks++; if ({s, ix} !== {1'b0, inxTab[i]}) begin failures++; $display("[TB] FAIL f2i_flags[%0d]: got %b expected %b", i, {s, ix}, {1'b0, inxTab[i]}); end
    end
  endtask

  task automatic test_saturation();
    logic [1:0]  opTab  [4] = '{2'b10, 2'b10, 2'b11, 2'b11};
    logic [31:0] inTab  [4] = '{32'h004F_8000, 32'h00CF_0000, 32'h00C0_0000, 32'h004F_8000};
    logic [31:0] resTab [4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
    logic        satTab [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] res; logic [5:0] tg; logic s, ix; int lat;
    for (int i = 0; i < 4; i++) begin
      runOne(opTab[i], inTab[i], 6'(i + 20), res, tg, s, ix, lat);
      checks++; if (res !== resTab[i]) begin failures++; $display("[TB] FAIL sat_result[%0d]: got %h expected %h (latency %0d)", i, res, resTab[i], lat); end
      checks++; if ({s, ix} !== {satTab[i], 1'b0}) begin failures++; $display("[TB] FAIL sat_flags[%0d]: got %b expected %b", i, {s, ix}, {satTab[i], 1'b0}); end
    end
  endtask

  task automatic test_random();
    logic [1:0] op; logic [31:0] data, res, eRes; logic [5:0] tag, tg; logic s, ix, eSat, eInx; int lat;
    for (int i = 0; i < 120; i++) begin
      op   = 2'($urandom_range(0, 3));
      data = randOperand(op);
      tag  = 6'($urandom);
      refConvert(op, data, eRes, eSat, eInx);
      runOne(op, data, tag, res, tg, s, ix, lat);
      checks++;
      if (lat == 0 || res !== eRes || {s, ix} !== {eSat, eInx} || tg !== tag) begin
        failures++;
        $display("[TB] FAIL random[%0d] op=%b data=%h: got %h s=%b i=%b tag=%h lat=%0d expected %h s=%b i=%b tag=%h",
                 i, op, data, res, s, ix, tg, lat, eRes, eSat, eInx, tag);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] expRes[$]; logic [5:0] expTag[$]; logic expSat[$]; logic expInx[$];
    int got = 0, stallSeen = 0;
    @(posedge clk_i); #1;
    fork
      begin
        logic [1:0] op; logic [31:0] data, eRes; logic eSat, eInx, accepted;
        for (int i = 0; i < 8; i++) begin
          op = 2'($urandom_range(0, 3));
          data = randOperand(op);
          cvtBus.in_valid_i = 1'b1; cvtBus.op_i = op; cvtBus.data_i = data; cvtBus.tag_i = 6'(i);
          accepted = 1'b0;
          for (int w = 0; w < 40 && !accepted; w++) begin
            @(negedge clk_i);
            accepted = cvtBus.in_ready_o;
            @(posedge clk_i); #1;
          end
          if (accepted) begin
            refConvert(op, data, eRes, eSat, eInx);
            expRes.push_back(eRes); expTag.push_back(6'(i)); expSat.push_back(eSat); expInx.push_back(eInx);
          end
        end
        cvtBus.in_valid_i = 1'b0;
      end
      begin
        for (int c = 0; c < 14; c++) begin
          cvtBus.out_ready_i = !(c >= 4 && c < 9);
          @(posedge clk_i); #1;
        end
        cvtBus.out_ready_i = 1'b1;
      end
      begin
        logic [39:0] held, cur; logic wasStalled;
        wasStalled = 1'b0; held = '0;
        for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
          @(negedge clk_i);
          cur = {cvtBus.result_o, cvtBus.tag_o, cvtBus.sat_o, cvtBus.inexact_o};
          if (cvtBus.out_valid_o && !cvtBus.out_ready_i) begin
            stallSeen++;
            checks++; if (cvtBus.in_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL stall_in_ready: got %b expected 0", cvtBus.in_ready_o); end
            if (wasStalled) begin
              checks++; if (cur !== held) begin failures++; $display("[TB] FAIL stall_hold: got %h expected %h", cur, held); end
            end
            held = cur; wasStalled = 1'b1;
          end else begin
            wasStalled = 1'b0;
            if (cvtBus.out_valid_o && cvtBus.out_ready_i) begin
              checks++;
              if (expRes.size() == 0) begin
                failures++; $display("[TB] FAIL stream_extra: got result %h tag %h expected none", cvtBus.result_o, cvtBus.tag_o);
              end else begin
                if (cur !== {expRes[0], expTag[0], expSat[0], expInx[0]}) begin
                  failures++; $display("[TB] FAIL stream_result: got %h expected %h", cur, {expRes[0], expTag[0], expSat[0], expInx[0]});
                end
                void'(expRes.pop_front()); void'(expTag.pop_front()); void'(expSat.pop_front()); void'(expInx.pop_front());
              end
              got++;
            end
          end
        end
      end
    join
    checks++; if (got != 8) begin failures++; $display("[TB] FAIL stream_count: got %0d expected 8", got); end
    checks++; if (stallSeen != 5) begin failures++; $display("[TB] FAIL stream_stall_cycles: got %0d expected 5", stallSeen); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      checks++; if (cvtBus.out_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL stream_duplicate: got out_valid %b expected 0", cvtBus.out_valid_o); end
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] res; logic [5:0] tg; logic s, ix; int lat;
    @(posedge clk_i); #1;
    cvtBus.out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cvtBus.in_valid_i = 1'b1; cvtBus.op_i = 2'b00; cvtBus.data_i = $urandom; cvtBus.tag_i = 6'(40 + i);
      @(posedge clk_i); #1;
    end
    cvtBus.in_valid_i = 1'b0;
    @(posedge clk_i); #2;
    checks++; if (cvtBus.out_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL midop_inflight: got out_valid %b expected 1", cvtBus.out_valid_o); end
    rst_ni = 1'b0;
    #1;
    checks++; if (cvtBus.out_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL midop_async_clear: got out_valid %b expected 0", cvtBus.out_valid_o); end
    checks++; if ({cvtBus.result_o, cvtBus.tag_o} !== 38'h0) begin failures++; $display("[TB] FAIL midop_clear_payload: got %h expected 0", {cvtBus.result_o, cvtBus.tag_o}); end
    #1 rst_ni = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      checks++; if (cvtBus.out_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL midop_stale[%0d]: got out_valid %b expected 0", k, cvtBus.out_valid_o); end
    end
    runOne(2'b00, 32'd1, 6'd9, res, tg, s, ix, lat);
    checks++; if (lat != 4) begin failures++; $display("[TB] FAIL midop_latency: got %0d expected 4", lat); end
    checks++; if ({res, tg} !== {32'h003F_8000, 6'd9}) begin failures++; $display("[TB] FAIL midop_result: got %h/%h expected 003f8000/09", res, tg); end
  endtask

  initial begin
    cvtBus.in_valid_i  = 1'b0;
    cvtBus.op_i        = 2'b00;
    cvtBus.data_i      = '0;
    cvtBus.tag_i       = '0;
    cvtBus.out_ready_i = 1'b1;
    $display("[TB] starting fp_cvt bench");
    test_reset();
    test_int_to_fp();
    test_fp_to_int();
    test_saturation();
    test_random();
    test_back_to_back();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion by %0t expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
